// File: rtl/mem_router.sv
// Single-master memory router: decodes one request against the slave address
// map, forwards it to exactly one slave with a base-relative address, tracks the
// outstanding transaction and returns the selected slave's response, or an error
// response for unmapped addresses and for slaves that never answer.

package configure;

  localparam logic [31:0] ram_base_addr   = 32'h0001_0000;
  localparam logic [31:0] ram_top_addr    = 32'h0002_0000;
  localparam logic [31:0] dtim_base_addr  = 32'h1000_0000;
  localparam logic [31:0] dtim_top_addr   = 32'h1000_2000;
  localparam logic [31:0] itim_base_addr  = 32'h1001_0000;
  localparam logic [31:0] itim_top_addr   = 32'h1001_2000;
  localparam logic [31:0] clint_base_addr = 32'h0200_0000;
  localparam logic [31:0] clint_top_addr  = 32'h0201_0000;
  localparam logic [31:0] print_base_addr = 32'h2000_0000;
  localparam logic [31:0] print_top_addr  = 32'h2000_0010;
  localparam logic [31:0] rom_base_addr   = 32'h0000_1000;
  localparam logic [31:0] rom_top_addr    = 32'h0000_2000;

  // Index 0 is ram, 5 is rom; lower index wins when ranges overlap.
  localparam logic [5:0][31:0] slave_base = {rom_base_addr, print_base_addr, clint_base_addr,
                                             itim_base_addr, dtim_base_addr, ram_base_addr};
  localparam logic [5:0][31:0] slave_top  = {rom_top_addr, print_top_addr, clint_top_addr,
                                             itim_top_addr, dtim_top_addr, ram_top_addr};

endpackage

module mem_router
  import configure::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'h0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         memory_valid,
  input  logic         memory_instr,
  input  logic [31:0]  memory_addr,
  input  logic [31:0]  memory_wdata,
  input  logic [3:0]   memory_wstrb,
  output logic [31:0]  memory_rdata,
  output logic         memory_ready,
  output logic         memory_error,
  output logic [5:0]   slv_valid,
  output logic         slv_instr,
  output logic [31:0]  slv_addr,
  output logic [31:0]  slv_wdata,
  output logic [3:0]   slv_wstrb,
  input  logic [191:0] slv_rdata,
  input  logic [5:0]   slv_ready
);

  localparam int unsigned NUM_SLV = 6;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned CNT_W   = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] ERR  = 2'd2;
  localparam logic [1:0] TOUT = 2'd3;

  logic [1:0]         state, state_nxt;
  logic [SEL_W-1:0]   sel, sel_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [NUM_SLV-1:0] hit;
  logic               dec_hit;
  logic [SEL_W-1:0]   dec_idx;
  logic               can_accept;

  // Per-slave half-open range match.
  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      hit[i] = (memory_addr >= slave_base[i]) && (memory_addr < slave_top[i]);
    end
  end

  // Priority pick of the lowest-index matching slave.
  always_comb begin
    dec_hit = |hit;
    dec_idx = '0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if (hit[i]) dec_idx = SEL_W'(i);
    end
  end

  // Shared datapath copies and base-relative address.
  always_comb begin
    slv_instr = memory_instr;
    slv_wdata = memory_wdata;
    slv_wstrb = memory_wstrb;
    slv_addr  = dec_hit ? (memory_addr - slave_base[dec_idx]) : memory_addr;
  end

  // Next-state, request forwarding and response generation.
  always_comb begin
    state_nxt    = IDLE;
    sel_nxt      = sel;
    cnt_nxt      = cnt;
    slv_valid    = '0;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    memory_rdata = '0;
    can_accept   = 1'b0;

    case (state)
      IDLE: can_accept = 1'b1;
      BUSY: begin
        if (slv_ready[sel]) begin
          memory_ready = 1'b1;
          memory_rdata = slv_rdata[32*sel +: 32];
          can_accept   = 1'b1;
        end else begin
          state_nxt = (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) ? TOUT : BUSY;
          if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ERR, TOUT: begin
        memory_ready = 1'b1;
        memory_error = 1'b1;
        memory_rdata = ERR_RDATA;
        can_accept   = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase

    // A new request is taken whenever no transaction remains outstanding.
    if (can_accept && memory_valid) begin
      cnt_nxt = '0;
      if (dec_hit) begin
        slv_valid = NUM_SLV'(1) << dec_idx;
        sel_nxt   = dec_idx;
        state_nxt = BUSY;
      end else begin
        state_nxt = ERR;
      end
    end

    // Reset suppresses every request and response in the same cycle.
    if (reset) begin
      slv_valid    = '0;
      memory_ready = 1'b0;
      memory_error = 1'b0;
      memory_rdata = '0;
    end
  end

  // State, selected slave and timeout counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      sel   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mem_router.sv
// Self-checking bench for mem_router: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// transaction-level model (outstanding request, its age, pending error).

module tb_mem_router;
  import configure::*;

  localparam int unsigned TO      = 4;
  localparam logic [31:0] ERR_VAL = 32'h0;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         memory_valid = 1'b0;
  logic         memory_instr = 1'b0;
  logic [31:0]  memory_addr = '0;
  logic [31:0]  memory_wdata = '0;
  logic [3:0]   memory_wstrb = '0;
  logic [31:0]  memory_rdata;
  logic         memory_ready;
  logic         memory_error;
  logic [5:0]   slv_valid;
  logic         slv_instr;
  logic [31:0]  slv_addr;
  logic [31:0]  slv_wdata;
  logic [3:0]   slv_wstrb;
  logic [191:0] slv_rdata = '0;
  logic [5:0]   slv_ready = '0;

  int checks = 0;
  int errors = 0;

  // Model state: one outstanding request with its age, or an error due next cycle.
  bit m_pending = 0;
  int m_sel = 0;
  int m_age = 0;
  bit m_err = 0;

  always #5 clock = ~clock;

  mem_router #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(ERR_VAL)) dut (
    .clock(clock), .reset(reset),
    .memory_valid(memory_valid), .memory_instr(memory_instr), .memory_addr(memory_addr),
    .memory_wdata(memory_wdata), .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
    .memory_ready(memory_ready), .memory_error(memory_error),
    .slv_valid(slv_valid), .slv_instr(slv_instr), .slv_addr(slv_addr),
    .slv_wdata(slv_wdata), .slv_wstrb(slv_wstrb), .slv_rdata(slv_rdata), .slv_ready(slv_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output bit h, output int idx);
    h = 0;
    idx = 0;
    for (int i = 0; i < 6; i++) begin
      if (!h && a >= slave_base[i] && a < slave_top[i]) begin
        h = 1;
        idx = i;
      end
    end
  endfunction

  // One model step per cycle: predict this cycle's outputs, compare, advance.
  task automatic model_cycle();
    bit h, seen, acc;
    int idx;
    logic [5:0]  e_sv;
    logic [31:0] e_addr, e_rd;
    logic        e_rdy, e_err;
    decode(memory_addr, h, idx);
    e_addr = h ? memory_addr - slave_base[idx] : memory_addr;
    e_sv = '0; e_rd = '0; e_rdy = 0; e_err = 0; seen = 0; acc = 0;
    if (!reset) begin
      if (m_err) begin
        e_rdy = 1; e_err = 1; e_rd = ERR_VAL;
      end else if (m_pending && slv_ready[m_sel]) begin
        seen = 1; e_rdy = 1; e_rd = slv_rdata[32*m_sel +: 32];
      end
      acc = memory_valid && (!m_pending || seen);
      if (acc && h) e_sv = 6'(1) << idx;
    end
    chk("m_slv_valid", 32'(slv_valid), 32'(e_sv));
    chk("m_slv_addr", slv_addr, e_addr);
    chk("m_ready", 32'(memory_ready), 32'(e_rdy));
    chk("m_error", 32'(memory_error), 32'(e_err));
    chk("m_rdata", memory_rdata, e_rd);
    chk("m_copies", {slv_wdata[26:0], slv_wstrb, slv_instr},
        {memory_wdata[26:0], memory_wstrb, memory_instr});
    if (reset) begin
      m_pending = 0;
      m_err = 0;
    end else begin
      m_err = 0;
      if (acc) begin
        if (h) begin m_pending = 1; m_sel = idx; m_age = 1; end
        else begin m_pending = 0; m_err = 1; end
      end else if (seen) begin
        m_pending = 0;
      end else if (m_pending) begin
        if (m_age == int'(TO)) begin m_pending = 0; m_err = 1; end
        else m_age++;
      end
    end
  endtask

  // Compare process, away from the active edge.
  always @(negedge clock) model_cycle();

  // Advance one cycle and clear single-cycle pulses.
  task automatic cyc();
    @(posedge clock);
    #1;
    memory_valid = 0;
    slv_ready = '0;
  endtask

  task automatic req(input logic [31:0] a, input logic [3:0] s);
    memory_valid = 1;
    memory_addr = a;
    memory_wstrb = s;
    memory_wdata = $urandom;
    memory_instr = 1'($urandom);
  endtask

  initial begin
    // Reset with a request present: nothing may be forwarded.
    req(ram_base_addr, 4'h0);
    #2;
    chk("rst_slv_valid", 32'(slv_valid), 32'h0);
    @(posedge clock); #1;
    chk("rst_ready", 32'(memory_ready), 32'h0);
    chk("rst_rdata", memory_rdata, 32'h0);
    cyc(); reset = 0;
    cyc();

    // Read ram.
    cyc(); req(ram_base_addr + 32'h10, 4'h0); #1;
    chk("ram_slv_valid", 32'(slv_valid), 32'h01);
    chk("ram_slv_addr", slv_addr, 32'h10);
    cyc(); slv_ready[0] = 1; slv_rdata[31:0] = 32'hDEADBEEF; #1;
    chk("ram_ready", 32'(memory_ready), 32'h1);
    chk("ram_rdata", memory_rdata, 32'hDEADBEEF);
    chk("ram_error", 32'(memory_error), 32'h0);
    cyc();

    // Unmapped write.
    cyc(); req(32'h3000_0000, 4'hF); #1;
    chk("unm_slv_valid", 32'(slv_valid), 32'h0);
    chk("unm_slv_addr", slv_addr, 32'h3000_0000);
    cyc(); #1;
    chk("unm_ready", 32'(memory_ready), 32'h1);
    chk("unm_error", 32'(memory_error), 32'h1);
    chk("unm_rdata", memory_rdata, 32'h0);
    cyc();

    // Timeout on clint, then a late clint ready.
    cyc(); req(clint_base_addr + 32'h8, 4'h0); #1;
    chk("to_slv_valid", 32'(slv_valid), 32'h08);
    for (int k = 1; k <= int'(TO); k++) begin
      cyc(); #1;
      chk("to_early_ready", 32'(memory_ready), 32'h0);
    end
    cyc(); #1;
    chk("to_ready", 32'(memory_ready), 32'h1);
    chk("to_error", 32'(memory_error), 32'h1);
    cyc();
    cyc(); slv_ready[3] = 1; slv_rdata[127:96] = 32'h5555_AAAA; #1;
    chk("to_late_ready", 32'(memory_ready), 32'h0);
    cyc();

    // Stray ready from rom while dtim is outstanding.
    cyc(); req(dtim_base_addr + 32'h40, 4'h3); #1;
    chk("stray_slv_addr", slv_addr, 32'h40);
    cyc(); slv_ready[5] = 1; slv_rdata[191:160] = 32'hFFFF_0000; #1;
    chk("stray_rom_ignored", 32'(memory_ready), 32'h0);
    cyc(); #1;
    chk("stray_gap", 32'(memory_ready), 32'h0);
    cyc(); slv_ready[1] = 1; slv_rdata[63:32] = 32'h12345678; #1;
    chk("stray_ready", 32'(memory_ready), 32'h1);
    chk("stray_rdata", memory_rdata, 32'h12345678);
    cyc();

    // Back-to-back itim then print.
    cyc(); req(itim_base_addr, 4'h0); #1;
    chk("b2b_itim_valid", 32'(slv_valid), 32'h04);
    cyc(); slv_ready[2] = 1; slv_rdata[95:64] = 32'hCAFE_0001;
    req(print_base_addr + 32'h4, 4'h1); #1;
    chk("b2b_itim_ready", 32'(memory_ready), 32'h1);
    chk("b2b_itim_rdata", memory_rdata, 32'hCAFE_0001);
    chk("b2b_print_valid", 32'(slv_valid), 32'h10);
    chk("b2b_print_addr", slv_addr, 32'h4);
    cyc(); slv_ready[4] = 1; slv_rdata[159:128] = 32'h0000_00A5; #1;
    chk("b2b_print_ready", 32'(memory_ready), 32'h1);
    chk("b2b_print_rdata", memory_rdata, 32'h0000_00A5);
    cyc();

    // Reset while rom is outstanding.
    cyc(); req(rom_base_addr + 32'h100, 4'h0); #1;
    chk("rst_rom_valid", 32'(slv_valid), 32'h20);
    cyc(); reset = 1; #1;
    chk("rstb_ready", 32'(memory_ready), 32'h0);
    chk("rstb_error", 32'(memory_error), 32'h0);
    chk("rstb_rdata", memory_rdata, 32'h0);
    chk("rstb_slv_valid", 32'(slv_valid), 32'h0);
    cyc(); reset = 0; slv_ready[5] = 1; slv_rdata[191:160] = 32'h7777_7777; #1;
    chk("rstb_late_ready", 32'(memory_ready), 32'h0);
    cyc(); req(ram_base_addr + 32'h20, 4'hF); #1;
    chk("rstb_ram_valid", 32'(slv_valid), 32'h01);
    cyc(); slv_ready[0] = 1; slv_rdata[31:0] = 32'h0BAD_F00D; #1;
    chk("rstb_ram_ready", 32'(memory_ready), 32'h1);
    chk("rstb_ram_rdata", memory_rdata, 32'h0BAD_F00D);
    cyc();

    // Randomized traffic, checked by the model process.
    for (int n = 0; n < 3000; n++) begin
      int r;
      cyc();
      reset = ($urandom % 250) == 0;
      r = int'($urandom % 8);
      if (r < 6) memory_addr = slave_base[r] + ($urandom % (slave_top[r] - slave_base[r]));
      else if (r == 6) memory_addr = slave_top[$urandom % 6];
      else memory_addr = $urandom;
      memory_valid = 1'($urandom % 2);
      memory_instr = 1'($urandom);
      memory_wdata = $urandom;
      memory_wstrb = 4'($urandom);
      for (int k = 0; k < 6; k++) begin
        slv_ready[k] = ($urandom % 3) == 0;
        slv_rdata[32*k +: 32] = $urandom;
      end
    end
    cyc(); reset = 0;
    repeat (TO + 3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
